packet_tick_sched: RTL

Multi-channel programmable interval timer that generates periodic transmit-trigger events for the LAN8720 packet path. It generalises the single fixed 100 ms packet enable into CHANNELS independent channels. Each channel has a runtime-writable period, periodic or one-shot mode, and a req/ack event handshake with overrun detection. It sits between the configuration logic and the per-stream packet builders, all in the 50 MHz RMII clock domain.

---
 rtl/packet_tick_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/packet_tick_sched.sv
// packet_tick_sched: multi-channel programmable interval timer for the RMII
// packet path. Each channel counts its own period, raises a one-cycle tick,
// holds req until it is acknowledged, and flags overrun when a tick arrives
// while the previous event is still unacknowledged.
// Optional feature macro: PKT_SCHED_SIM_LEAD_EN -- when defined, a channel
// leaving IDLE starts its counter SIM_LEAD cycles short of the period, so the
// first tick comes quickly in simulation; later ticks keep the full period.
module packet_tick_sched #(
    parameter int          CHANNELS       = 4,
    parameter int          CNT_W          = 32,
    parameter int unsigned PERIOD_DEFAULT = 5000000,
    parameter int unsigned SIM_LEAD       = 40
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [CHANNELS-1:0]                               ch_en,
    input  logic [CHANNELS-1:0]                               one_shot,
    input  logic                                              cfg_we,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                                  cfg_period,
    input  logic [CHANNELS-1:0]                               ack,
    input  logic [CHANNELS-1:0]                               ovr_clr,
    output logic [CHANNELS-1:0]                               tick,
    output logic [CHANNELS-1:0]                               req,
    output logic [CHANNELS-1:0]                               overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef PKT_SCHED_SIM_LEAD_EN
    localparam bit LEAD_EN = 1'b1;
`else
    localparam bit LEAD_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LEAD      = CNT_W'(SIM_LEAD);
    localparam logic [CNT_W-1:0] PER_RESET = CNT_W'(PERIOD_DEFAULT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [1:0]          state     [CHANNELS];
    logic [CNT_W-1:0]    cnt       [CHANNELS];
    logic [CNT_W-1:0]    period    [CHANNELS];
    logic [CNT_W-1:0]    start_val [CHANNELS];
    logic [CHANNELS-1:0] os_lat;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] tick_set;

    // Per-channel decode: period write hit, tick due on this edge, and the
    // counter value loaded when a channel starts running. An out-of-range
    // cfg_ch matches no channel, so such writes are dropped. A write to a
    // running channel suppresses any tick due on the same edge.
    always_comb begin
        wr_hit   = '0;
        tick_set = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            start_val[i] = '0;
            wr_hit[i]    = cfg_we && (int'(cfg_ch) == i);
            tick_set[i]  = ch_en[i] && (state[i] == ST_RUN) && (period[i] != '0)
                           && !wr_hit[i] && (cnt[i] == period[i] - ONE);
            if (LEAD_EN && (period[i] > LEAD)) begin
                start_val[i] = period[i] - LEAD;
            end
        end
    end

    // Channel state, counters, period registers and the event handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick    <= '0;
            req     <= '0;
            overrun <= '0;
            os_lat  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state[i]  <= ST_IDLE;
                cnt[i]    <= '0;
                period[i] <= PER_RESET;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_hit[i]) begin
                    period[i] <= cfg_period;
                end

                tick[i] <= tick_set[i];

                if (tick_set[i]) begin
                    req[i] <= 1'b1;
                end else if (ack[i]) begin
                    req[i] <= 1'b0;
                end

                if (tick_set[i] && req[i] && !ack[i]) begin
                    overrun[i] <= 1'b1;
                end else if (ovr_clr[i]) begin
                    overrun[i] <= 1'b0;
                end

                if (!ch_en[i]) begin
                    state[i] <= ST_IDLE;
                    cnt[i]   <= '0;
                end else begin
                    case (state[i])
                        ST_IDLE: begin
                            if (period[i] != '0) begin
                                state[i]  <= ST_RUN;
                                cnt[i]    <= start_val[i];
                                os_lat[i] <= one_shot[i];
                            end
                        end
                        ST_RUN: begin
                            if (period[i] == '0) begin
                                state[i] <= ST_IDLE;
                                cnt[i]   <= '0;
                            end else if (wr_hit[i]) begin
                                cnt[i] <= '0;
                            end else if (tick_set[i]) begin
                                cnt[i] <= '0;
                                if (os_lat[i]) begin
                                    state[i] <= ST_DONE;
                                end
                            end else begin
                                cnt[i] <= cnt[i] + ONE;
                            end
                        end
                        default: begin
                            state[i] <= ST_DONE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
